// File: rtl/fetch_if.sv
// Bundle between the fetch stage and its neighbours (instruction memory, decode, branch unit).
// FETCH_PERF_CNT_EN adds the fetch/bubble performance counters.
interface fetch_if;
  // Decode-side control
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [7:0]  branch_target;

  // Instruction memory side (combinational memory, zero latency)
  logic [7:0]  im_addr;
  logic [15:0] im_instr;

  // Stage state and IF/ID register
  logic [7:0]  pc;
  logic [7:0]  ifid_pc;
  logic [15:0] ifid_instr;
  logic        ifid_valid;
  logic        halted;
  logic        state_dbg;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_count;
  logic [15:0] bubble_count;
`endif

  modport master (
    input  stall, flush, branch_taken, branch_target, im_instr,
    output im_addr, pc, ifid_pc, ifid_instr, ifid_valid, halted, state_dbg
`ifdef FETCH_PERF_CNT_EN
    , output fetch_count, bubble_count
`endif
  );

  modport slave (
    output stall, flush, branch_taken, branch_target, im_instr,
    input  im_addr, pc, ifid_pc, ifid_instr, ifid_valid, halted, state_dbg
`ifdef FETCH_PERF_CNT_EN
    , input fetch_count, bubble_count
`endif
  );
endinterface

// File: rtl/fetch_stage.sv
// PC generation and IF/ID capture in front of a combinational instruction memory.
// Optional FETCH_PERF_CNT_EN adds saturating fetch/bubble counters.
module fetch_stage #(
  parameter logic [7:0]  PC_RESET   = 8'h00,
  parameter logic [7:0]  PC_STEP    = 8'd2,
  parameter logic [7:0]  PC_LIMIT   = 8'h3A,
  parameter logic [15:0] NOP_INSTR  = 16'h0000,
  parameter logic [15:0] HALT_INSTR = 16'hEFFF
) (
  input logic   clk,
  input logic   reset,
  fetch_if.master bus
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t      state;
  logic [7:0]  pc_q;
  logic [7:0]  ifid_pc_q;
  logic [15:0] ifid_instr_q;
  logic        ifid_valid_q;
  logic [8:0]  pc_sum;
  logic [7:0]  pc_next;

  // Sum is 9 bits wide so an 8-bit overflow also lands on the wrap path.
  assign pc_sum  = {1'b0, pc_q} + {1'b0, PC_STEP};
  assign pc_next = (pc_sum >= {1'b0, PC_LIMIT}) ? PC_RESET : pc_sum[7:0];

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_cnt_q;
  logic [15:0] bubble_cnt_q;
  logic        cnt_fetch;
  logic        cnt_bubble;

  always_comb begin
    cnt_fetch  = 1'b0;
    cnt_bubble = 1'b0;
    if (bus.branch_taken || bus.flush) begin
      cnt_bubble = 1'b1;
    end else if (!bus.stall) begin
      if (state == RUN) cnt_fetch  = 1'b1;
      else              cnt_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q  <= 16'h0000;
      bubble_cnt_q <= 16'h0000;
    end else begin
      if (cnt_fetch  && fetch_cnt_q  != 16'hFFFF) fetch_cnt_q  <= fetch_cnt_q  + 16'd1;
      if (cnt_bubble && bubble_cnt_q != 16'hFFFF) bubble_cnt_q <= bubble_cnt_q + 16'd1;
    end
  end

  assign bus.fetch_count  = fetch_cnt_q;
  assign bus.bubble_count = bubble_cnt_q;
`endif

  // IF/ID handshake: ifid_valid marks a real instruction; decode holds it by
  // asserting stall, and a flush or branch replaces it with a bubble even under stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      pc_q         <= PC_RESET;
      ifid_pc_q    <= 8'h00;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
    end else if (bus.branch_taken) begin
      state        <= RUN;
      pc_q         <= {bus.branch_target[7:1], 1'b0};
      ifid_pc_q    <= pc_q;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
    end else if (bus.flush) begin
      // A halted stage stays frozen; only a running one keeps advancing.
      if (state == RUN) pc_q <= pc_next;
      ifid_pc_q    <= pc_q;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
    end else if (!bus.stall) begin
      case (state)
        RUN: begin
          ifid_pc_q    <= pc_q;
          ifid_instr_q <= bus.im_instr;
          ifid_valid_q <= 1'b1;
          if (bus.im_instr == HALT_INSTR) state <= HALT;
          else                            pc_q  <= pc_next;
        end
        HALT: begin
          ifid_instr_q <= NOP_INSTR;
          ifid_valid_q <= 1'b0;
        end
        default: state <= RUN;
      endcase
    end
  end

  assign bus.im_addr    = pc_q;
  assign bus.pc         = pc_q;
  assign bus.ifid_pc    = ifid_pc_q;
  assign bus.ifid_instr = ifid_instr_q;
  assign bus.ifid_valid = ifid_valid_q;
  assign bus.halted     = (state == HALT);
  assign bus.state_dbg  = state;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then randomized control against a
// cycle-level reference model of the fetch rules.
module tb_fetch_stage;

  localparam logic [15:0] HALT_W = 16'hEFFF;
  localparam logic [15:0] NOP_W  = 16'h0000;

  logic clk;
  logic reset;
  logic [15:0] mem [256];

  fetch_if bus ();

  fetch_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  assign bus.im_instr = mem[bus.im_addr];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  int n_total = 0;
  int n_bad   = 0;

  logic [7:0]  m_pc;
  logic [7:0]  m_ifid_pc;
  logic [15:0] m_instr;
  logic        m_valid;
  logic        m_halted;
  int          m_fetches;
  int          m_bubbles;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] advance(input logic [7:0] p);
    int s;
    s = int'(p) + 2;
    return (s >= 'h3A) ? 8'h00 : 8'(s);
  endfunction

  // Reference: apply one clock edge worth of the priority rules.
  task automatic model_edge(input logic r, input logic br, input logic [7:0] bt,
                            input logic fl, input logic st);
    logic [15:0] word;
    word = mem[m_pc];
    if (r) begin
      m_pc = 8'h00; m_ifid_pc = 8'h00; m_instr = NOP_W; m_valid = 1'b0; m_halted = 1'b0;
      m_fetches = 0; m_bubbles = 0;
    end else if (br) begin
      m_ifid_pc = m_pc; m_pc = bt & 8'hFE; m_instr = NOP_W; m_valid = 1'b0; m_halted = 1'b0;
      m_bubbles++;
    end else if (fl) begin
      m_ifid_pc = m_pc; m_instr = NOP_W; m_valid = 1'b0;
      if (!m_halted) m_pc = advance(m_pc);
      m_bubbles++;
    end else if (st) begin
      // everything holds
    end else if (!m_halted) begin
      m_ifid_pc = m_pc; m_instr = word; m_valid = 1'b1; m_fetches++;
      if (word == HALT_W) m_halted = 1'b1;
      else                m_pc = advance(m_pc);
    end else begin
      m_instr = NOP_W; m_valid = 1'b0; m_bubbles++;
    end
  endtask

  task automatic compare_all();
    check("pc",         {8'h00, bus.pc},      {8'h00, m_pc});
    check("im_addr",    {8'h00, bus.im_addr}, {8'h00, m_pc});
    check("ifid_pc",    {8'h00, bus.ifid_pc}, {8'h00, m_ifid_pc});
    check("ifid_instr", bus.ifid_instr,       m_instr);
    check("ifid_valid", {15'h0, bus.ifid_valid}, {15'h0, m_valid});
    check("halted",     {15'h0, bus.halted},  {15'h0, m_halted});
`ifdef FETCH_PERF_CNT_EN
    check("fetch_count",  bus.fetch_count,  16'(m_fetches));
    check("bubble_count", bus.bubble_count, 16'(m_bubbles));
`endif
  endtask

  // driver: present inputs, advance one edge, compare against the model
  task automatic step(input logic r, input logic br, input logic [7:0] bt,
                      input logic fl, input logic st);
    reset = r; bus.branch_taken = br; bus.branch_target = bt; bus.flush = fl; bus.stall = st;
    model_edge(r, br, bt, fl, st);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic jump(input logic [7:0] t);
    step(1'b0, 1'b1, t, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; bus.stall = 1'b0; bus.flush = 1'b0;
    bus.branch_taken = 1'b0; bus.branch_target = 8'h00;
    for (int a = 0; a < 256; a++) mem[a] = 16'hF120;
    m_pc = 8'hXX; m_fetches = 0; m_bubbles = 0;

    // reset state
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    check("rst_pc",    {8'h00, bus.pc}, 16'h0000);
    check("rst_valid", {15'h0, bus.ifid_valid}, 16'h0000);
    check("rst_instr", bus.ifid_instr, 16'h0000);

    // straight-line fetch
    idle(4);
    check("seq_pc", {8'h00, bus.pc}, 16'h0008);
    check("seq_ifid_pc", {8'h00, bus.ifid_pc}, 16'h0006);

    // stall holds, release advances
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check("stall_pc", {8'h00, bus.pc}, 16'h0008);
    idle(1);
    check("unstall_pc", {8'h00, bus.pc}, 16'h000A);

    // branch with odd target
    jump(8'h10);
    jump(8'h25);
    check("br_pc", {8'h00, bus.pc}, 16'h0024);
    check("br_valid", {15'h0, bus.ifid_valid}, 16'h0000);
    idle(1);
    check("br_ifid_pc", {8'h00, bus.ifid_pc}, 16'h0024);

    // wrap at PC_LIMIT and at 8-bit overflow
    jump(8'h38);
    idle(1);
    check("wrap_limit", {8'h00, bus.pc}, 16'h0000);
    jump(8'hFF);
    check("br_ff", {8'h00, bus.pc}, 16'h00FE);
    idle(1);
    check("wrap_ovf", {8'h00, bus.pc}, 16'h0000);

    // halt detection and exit by branch
    mem[8'h36] = HALT_W;
    jump(8'h36);
    idle(1);
    check("halt_instr", bus.ifid_instr, HALT_W);
    check("halt_flag", {15'h0, bus.halted}, 16'h0001);
    idle(2);
    check("halt_pc", {8'h00, bus.pc}, 16'h0036);
    check("halt_bubble", {15'h0, bus.ifid_valid}, 16'h0000);
    jump(8'h00);
    check("unhalt", {15'h0, bus.halted}, 16'h0000);
    mem[8'h36] = 16'hF120;

    // simultaneous events
    jump(8'h0C);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    check("stall_flush_pc", {8'h00, bus.pc}, 16'h000E);
    step(1'b0, 1'b1, 8'h20, 1'b0, 1'b1);
    check("stall_br_pc", {8'h00, bus.pc}, 16'h0020);
    mem[8'h20] = HALT_W;
    idle(2);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    check("rst_halt_pc", {8'h00, bus.pc}, 16'h0000);
    check("rst_halt_flag", {15'h0, bus.halted}, 16'h0000);
    mem[8'h20] = 16'hF120;

    // randomized control against the model
    for (int a = 0; a < 256; a++)
      mem[a] = ($urandom_range(0, 15) == 0) ? HALT_W : 16'($urandom);
    for (int i = 0; i < 1500; i++) begin
      logic r, br, fl, st;
      logic [7:0] bt;
      r  = ($urandom_range(0, 99) == 0);
      br = ($urandom_range(0, 9) == 0);
      bt = 8'($urandom_range(0, 8'h3F));
      fl = ($urandom_range(0, 7) == 0);
      st = ($urandom_range(0, 4) == 0);
      // keep flush away from a frozen stage or a halt word in flight
      if (!br && (m_halted || mem[m_pc] == HALT_W)) fl = 1'b0;
      step(r, br, bt, fl, st);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
